serial_alu_seq: RTL

Bit-serial sequencer for the 1-bit ALU slice. It accepts a WIDTH-bit operation from the datapath, drives one slice bit position per clock, and assembles the slice's per-bit results into a WIDTH-bit result with zero, carry and overflow flags. The block sits directly upstream of the slice and also consumes its outputs. It is the area-reduced alternative to the 32-slice ripple ALU.

---
 rtl/serial_alu_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer that drives a 1-bit ALU slice one bit per clock and assembles a WIDTH-bit result.
// Optional macro SERIAL_ALU_SLT_OVF_EN: SLT corrects the sign bit with the overflow flag.
module serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             sl_src1_o,
  output logic             sl_src2_o,
  output logic             sl_less_o,
  output logic             sl_a_invert_o,
  output logic             sl_b_invert_o,
  output logic             sl_cin_o,
  output logic [1:0]       sl_operation_o,
  input  logic             sl_result_i,
  input  logic             sl_cout_i,
  input  logic             sl_overflow_i,
  input  logic             sl_set_i
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] a_reg,      a_next;
  logic [WIDTH-1:0] b_reg,      b_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             a_inv_reg,  a_inv_next;
  logic             b_inv_reg,  b_inv_next;
  logic [1:0]       op_reg,     op_next;
  logic             carry_reg,  carry_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic             cout_reg,   cout_next;
  logic             ovf_reg,    ovf_next;
  logic             set_reg,    set_next;

  logic             dec_a_inv;
  logic             dec_b_inv;
  logic [1:0]       dec_op;
  logic [WIDTH-1:0] result_run;
  logic             slt_bit;
  logic             run_active;

  always_comb begin
    dec_a_inv = 1'b0;
    dec_b_inv = 1'b0;
    dec_op    = OP_AND;
    case (ctrl_i)
      4'b0001: dec_op = OP_OR;
      4'b0010: dec_op = OP_ADD;
      4'b0110: begin dec_b_inv = 1'b1; dec_op = OP_ADD; end
      4'b0111: begin dec_b_inv = 1'b1; dec_op = OP_SLT; end
      4'b1100: begin dec_a_inv = 1'b1; dec_b_inv = 1'b1; dec_op = OP_AND; end
      default: dec_op = OP_AND;
    endcase
  end

  // Only the bit addressed by the counter takes the slice result this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_res
      assign result_run[gi] = (cnt_reg == CNT_W'(gi)) ? sl_result_i : result_reg[gi];
    end
  endgenerate

`ifdef SERIAL_ALU_SLT_OVF_EN
  assign slt_bit = set_reg ^ ovf_reg;
`else
  assign slt_bit = set_reg;
`endif

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    result_next = result_reg;
    a_inv_next  = a_inv_reg;
    b_inv_next  = b_inv_reg;
    op_next     = op_reg;
    carry_next  = carry_reg;
    cnt_next    = cnt_reg;
    cout_next   = cout_reg;
    ovf_next    = ovf_reg;
    set_next    = set_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_i) begin
          a_next      = src1_i;
          b_next      = src2_i;
          a_inv_next  = dec_a_inv;
          b_inv_next  = dec_b_inv;
          op_next     = dec_op;
          carry_next  = dec_b_inv;
          cnt_next    = '0;
          result_next = '0;
          state_next  = RUN;
        end else begin
          state_next  = IDLE;
        end
      end
      RUN: begin
        result_next = result_run;
        carry_next  = sl_cout_i;
        if (cnt_reg == LAST_BIT) begin
          cout_next  = sl_cout_i;
          ovf_next   = sl_overflow_i;
          set_next   = sl_set_i;
          state_next = (op_reg == OP_SLT) ? FIX : DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FIX: begin
        result_next    = '0;
        result_next[0] = slt_bit;
        state_next     = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      a_inv_reg  <= 1'b0;
      b_inv_reg  <= 1'b0;
      op_reg     <= OP_AND;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      set_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
      a_inv_reg  <= a_inv_next;
      b_inv_reg  <= b_inv_next;
      op_reg     <= op_next;
      carry_reg  <= carry_next;
      cnt_reg    <= cnt_next;
      cout_reg   <= cout_next;
      ovf_reg    <= ovf_next;
      set_reg    <= set_next;
    end
  end

  assign run_active     = (state_reg == RUN);
  assign busy_o         = (state_reg == RUN) || (state_reg == FIX);
  assign done_o         = (state_reg == DONE);
  assign result_o       = result_reg;
  assign zero_o         = (result_reg == '0);
  assign cout_o         = cout_reg;
  assign overflow_o     = ovf_reg;
  // Slice inputs are forced low whenever no bit is being processed.
  assign sl_src1_o      = run_active & a_reg[cnt_reg];
  assign sl_src2_o      = run_active & b_reg[cnt_reg];
  assign sl_cin_o       = run_active & carry_reg;
  assign sl_less_o      = 1'b0;
  assign sl_a_invert_o  = run_active & a_inv_reg;
  assign sl_b_invert_o  = run_active & b_inv_reg;
  assign sl_operation_o = run_active ? op_reg : OP_AND;

endmodule
